// File: rtl/frame_byte_packer.sv
// frame_byte_packer: packs an 8-bit byte stream into 32-bit keep-masked words behind a small FIFO
module frame_byte_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int BYTE_ORDER = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  inData,
    input  logic        inValid,
    input  logic        inLast,
    output logic        inReady,
    output logic [31:0] outData,
    output logic [3:0]  outKeep,
    output logic        outLast,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] wordCount,
    output logic [15:0] packetCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
    logic [1:0]    idx;
    logic [31:0]   accData;
    logic [3:0]    accKeep;
    logic [31:0]   memData [FIFO_DEPTH];
    logic [3:0]    memKeep [FIFO_DEPTH];
    logic          memLast [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          accept;
    logic          push;
    logic          pop;
    logic [1:0]    lane;
    logic [31:0]   nextData;
    logic [3:0]    nextKeep;
    always_comb begin
        inReady  = reset && (count < DEPTH);
        outValid = count != '0;
        accept   = inValid && inReady;
        lane     = (BYTE_ORDER != 0) ? 2'd3 - idx : idx;
        nextData = accData | ({24'd0, inData} << {lane, 3'b000});
        nextKeep = accKeep | (4'b0001 << lane);
        push     = accept && (idx == 2'd3 || inLast);
        pop      = outValid && outReady;
        // Outputs read as zero whenever the FIFO is empty, so reset/clear show a clean bus
        outData  = outValid ? memData[rdPtr] : '0;
        outKeep  = outValid ? memKeep[rdPtr] : '0;
        outLast  = outValid && memLast[rdPtr];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            accData     <= '0;
            accKeep     <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            wordCount   <= '0;
            packetCount <= '0;
        end else if (clear) begin
            idx         <= '0;
            accData     <= '0;
            accKeep     <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            wordCount   <= '0;
            packetCount <= '0;
        end else begin
            if (accept) begin
                idx     <= push ? 2'd0 : idx + 2'd1;
                accData <= push ? '0 : nextData;
                accKeep <= push ? '0 : nextKeep;
            end
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr     <= rdPtr + 1'b1;
                wordCount <= wordCount + 32'd1;
                if (outLast) packetCount <= packetCount + 16'd1;
            end
            if (push && !pop) count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            memData[wrPtr] <= nextData;
            memKeep[wrPtr] <= nextKeep;
            memLast[wrPtr] <= inLast;
        end
    end
endmodule
